// File: rtl/spi_reg_sender_pkg.sv
// Shared definitions for the raybox register SPI link: command codes, payload widths,
// FSM state encoding and the command-to-length table used by both ends of the link.
package spi_reg_sender_pkg;

    localparam int SPI_CMD_BITS = 4;
    localparam int DATA_BITS    = 24;
    localparam int FRAME_BITS   = SPI_CMD_BITS + DATA_BITS;
    localparam int CNT_BITS     = 5;
    localparam int TIMER_BITS   = 8;

    localparam logic [3:0] CMD_SKY     = 4'd0;
    localparam logic [3:0] CMD_FLOOR   = 4'd1;
    localparam logic [3:0] CMD_LEAK    = 4'd2;
    localparam logic [3:0] CMD_OTHER   = 4'd3;
    localparam logic [3:0] CMD_VSHIFT  = 4'd4;
    localparam logic [3:0] CMD_VINF    = 4'd5;
    localparam logic [3:0] CMD_MAPD    = 4'd6;
    localparam logic [3:0] CMD_TEXADD0 = 4'd7;
    localparam logic [3:0] CMD_TEXADD1 = 4'd8;
    localparam logic [3:0] CMD_TEXADD2 = 4'd9;
    localparam logic [3:0] CMD_TEXADD3 = 4'd10;

    localparam logic [4:0] LEN_COLOR   = 5'd6;
    localparam logic [4:0] LEN_OTHER   = 5'd12;
    localparam logic [4:0] LEN_VINF    = 5'd1;
    localparam logic [4:0] LEN_MAPD    = 5'd16;
    localparam logic [4:0] LEN_TEXADD  = 5'd24;
    localparam logic [4:0] LEN_DEFAULT = 5'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
        ST_TRAIL,
        ST_GAP
    } state_t;

    // Undefined codes fall back to 1 bit, matching the receiver's default.
    function automatic logic [4:0] spi_len(input logic [3:0] cmd);
        case (cmd)
            CMD_SKY, CMD_FLOOR, CMD_LEAK:             spi_len = LEN_COLOR;
            CMD_OTHER:                                spi_len = LEN_OTHER;
            CMD_VSHIFT:                               spi_len = LEN_COLOR;
            CMD_VINF:                                 spi_len = LEN_VINF;
            CMD_MAPD:                                 spi_len = LEN_MAPD;
            CMD_TEXADD0, CMD_TEXADD1,
            CMD_TEXADD2, CMD_TEXADD3:                 spi_len = LEN_TEXADD;
            default:                                  spi_len = LEN_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/spi_reg_sender_if.sv
// Command handshake between a host and the SPI register sender.
interface spi_reg_sender_if;
    import spi_reg_sender_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [SPI_CMD_BITS-1:0] cmd;
    logic [DATA_BITS-1:0]    data;
    logic                    busy;
    logic                    done;

    modport master (output cmd_valid, cmd, data, input cmd_ready, busy, done);
    modport slave  (input cmd_valid, cmd, data, output cmd_ready, busy, done);

endinterface

// File: rtl/spi_reg_sender_phase_timer.sv
// Loadable down-counter; phase_end is high while the count sits at zero.
module spi_reg_sender_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         phase_end
);

    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign phase_end = (count == '0);

endmodule

// File: rtl/spi_reg_sender.sv
// SPI mode-0 master sending one {cmd, payload} register frame per accepted command.
//
//   state | meaning
//   IDLE  | ss_n high, cmd_ready high, waiting for cmd_valid
//   LEAD  | ss_n low, sclk low, first bit on mosi
//   HIGH  | sclk high, receiver samples mosi
//   LOW   | sclk low, next bit presented on mosi
//   TRAIL | sclk low after the last bit, mosi held
//   GAP   | ss_n high before the next accept, done on the last cycle
module spi_reg_sender
    import spi_reg_sender_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    spi_reg_sender_if.slave  bus,
    output logic             o_sclk,
    output logic             o_ss_n,
    output logic             o_mosi
);

    localparam logic [TIMER_BITS-1:0] HALF_LOAD = TIMER_BITS'(HALF_PERIOD - 1);
    localparam logic [TIMER_BITS-1:0] GAP_LOAD  = TIMER_BITS'(GAP_CYCLES - 1);

    state_t                  state, state_next;
    logic [FRAME_BITS-1:0]   shreg, shreg_next;
    logic [CNT_BITS-1:0]     bits_left, bits_next;
    logic                    sclk_next, ss_n_next, mosi_next, done_next;
    logic                    t_load, phase_end;
    logic [TIMER_BITS-1:0]   t_value, t_count;
    logic [4:0]              len, shamt;
    logic [DATA_BITS-1:0]    data_aligned;

    assign len          = spi_len(bus.cmd);
    assign shamt        = 5'(DATA_BITS) - len;
    assign data_aligned = bus.data << shamt;

    spi_reg_sender_phase_timer #(.W(TIMER_BITS)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (t_load),
        .value     (t_value),
        .count     (t_count),
        .phase_end (phase_end)
    );

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        bits_next  = bits_left;
        sclk_next  = o_sclk;
        ss_n_next  = o_ss_n;
        mosi_next  = o_mosi;
        done_next  = 1'b0;
        t_load     = 1'b0;
        t_value    = HALF_LOAD;
        unique case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_next = ST_LEAD;
                    shreg_next = {bus.cmd, data_aligned};
                    bits_next  = 5'(SPI_CMD_BITS) + len;
                    ss_n_next  = 1'b0;
                    sclk_next  = 1'b0;
                    mosi_next  = bus.cmd[3];
                    t_load     = 1'b1;
                end
            end
            ST_LEAD, ST_LOW: begin
                if (phase_end) begin
                    state_next = ST_HIGH;
                    sclk_next  = 1'b1;
                    t_load     = 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    sclk_next = 1'b0;
                    t_load    = 1'b1;
                    if (bits_left > 5'd1) begin
                        state_next = ST_LOW;
                        // Rotation rather than plain shift; bits past the frame end are never sent.
                        shreg_next = {shreg[FRAME_BITS-2:0], shreg[FRAME_BITS-1]};
                        mosi_next  = shreg[FRAME_BITS-2];
                        bits_next  = bits_left - 5'd1;
                    end else begin
                        state_next = ST_TRAIL;
                    end
                end
            end
            ST_TRAIL: begin
                if (phase_end) begin
                    state_next = ST_GAP;
                    ss_n_next  = 1'b1;
                    mosi_next  = 1'b0;
                    t_load     = 1'b1;
                    t_value    = GAP_LOAD;
                end
            end
            ST_GAP: begin
                done_next = (t_count == TIMER_BITS'(1));
                if (phase_end)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            bits_left     <= '0;
            o_sclk        <= 1'b0;
            o_ss_n        <= 1'b1;
            o_mosi        <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.cmd_ready <= 1'b1;
        end else begin
            state         <= state_next;
            shreg         <= shreg_next;
            bits_left     <= bits_next;
            o_sclk        <= sclk_next;
            o_ss_n        <= ss_n_next;
            o_mosi        <= mosi_next;
            bus.busy      <= (state_next != ST_IDLE);
            bus.done      <= done_next;
            bus.cmd_ready <= (state_next == ST_IDLE);
        end
    end

endmodule
